// File: rtl/serializador_mux8_pkg.sv
// Shared definitions for the mux-driven serializer: state encoding and
// serial-line constants.
package serial_pkg;

    localparam logic TX_IDLE   = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARIDADE = 3'd3,
        STOP     = 3'd4
    } estado_t;

endpackage

// File: rtl/serializador_mux8_if.sv
// Producer handshake plus the B/Sel/S loop to the 8:1 mux and the serial line.
interface serializador_mux8_if;
    import serial_pkg::*;

    logic                 inicio;
    logic [DATA_BITS-1:0] dado;
    logic                 pronto;
    logic                 fim;
    logic [DATA_BITS-1:0] B;
    logic [2:0]           Sel;
    logic                 S;
    logic                 tx;

    modport master (output inicio, dado, S,
                    input  pronto, fim, B, Sel, tx);
    modport slave  (input  inicio, dado, S,
                    output pronto, fim, B, Sel, tx);
endinterface

// File: rtl/serializador_mux8_gerador_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled, tick on the last count.
module gerador_tick #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    // DIV=1 still needs a 1-bit counter; it just never leaves zero.
    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(DIV - 1);

    logic [CW-1:0] conta;

    assign tick = en && (conta == ULTIMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conta <= '0;
        end else if (!en || tick) begin
            conta <= '0;
        end else begin
            conta <= conta + CW'(1);
        end
    end
endmodule

// File: rtl/serializador_mux8.sv
// Latches a byte onto the mux inputs, steps Sel through it and shifts the
// returned mux bit out as a UART-style frame.
//
// state    | meaning
// IDLE     | pronto=1, tx idle, waiting for inicio
// START    | start bit (tx=0), Sel=0 so S already shows B[0]
// DATA     | data bit on tx, Sel one ahead of it
// PARIDADE | even parity of B (PARITY_EN=1 only)
// STOP     | stop bit; fim pulses on leaving
module serializador_mux8
    import serial_pkg::*;
#(
    parameter int DIV       = 16,
    parameter bit PARITY_EN = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    serializador_mux8_if.slave bus
);
    estado_t    estado;
    logic [2:0] idx_bit;
    logic       tick;

    gerador_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (estado != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= IDLE;
            idx_bit    <= '0;
            bus.B      <= '0;
            bus.Sel    <= '0;
            bus.tx     <= TX_IDLE;
            bus.pronto <= 1'b1;
            bus.fim    <= 1'b0;
        end else begin
            bus.fim <= 1'b0;
            case (estado)
                IDLE: begin
                    if (bus.inicio) begin
                        bus.B      <= bus.dado;
                        bus.Sel    <= '0;
                        bus.tx     <= 1'b0;
                        bus.pronto <= 1'b0;
                        estado     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bus.tx  <= bus.S;
                        bus.Sel <= bus.Sel + 3'd1;
                        idx_bit <= '0;
                        estado  <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        // Sel has already wrapped to 0 while bit 7 was on the line.
                        if (idx_bit == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN) begin
                                bus.tx <= ^bus.B;
                                estado <= PARIDADE;
                            end else begin
                                bus.tx <= TX_IDLE;
                                estado <= STOP;
                            end
                        end else begin
                            bus.tx  <= bus.S;
                            bus.Sel <= bus.Sel + 3'd1;
                            idx_bit <= idx_bit + 3'd1;
                        end
                    end
                end
                PARIDADE: begin
                    if (tick) begin
                        bus.tx <= TX_IDLE;
                        estado <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        bus.tx     <= TX_IDLE;
                        bus.pronto <= 1'b1;
                        bus.fim    <= 1'b1;
                        estado     <= IDLE;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serializador_mux8.sv
// Three serializer instances (DIV 4/2/1, parity off/on/off) checked cycle by
// cycle against a frame-level model of the serial line.
module tb_serializador_mux8;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] last_b [3];

    serializador_mux8_if if0 ();
    serializador_mux8_if if1 ();
    serializador_mux8_if if2 ();

    // behavioural 8:1 mux closing the loop
    assign if0.S = if0.B[if0.Sel];
    assign if1.S = if1.B[if1.Sel];
    assign if2.S = if2.B[if2.Sel];

    serializador_mux8 #(.DIV(4), .PARITY_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    serializador_mux8 #(.DIV(2), .PARITY_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serializador_mux8 #(.DIV(1), .PARITY_EN(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        case (i)
            0: return 4;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int par_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    // sig: 0 tx, 1 pronto, 2 fim, 3 Sel, 4 B
    function automatic logic [31:0] rd(input int i, input int sig);
        logic [31:0] v;
        v = '0;
        case (i)
            0: case (sig)
                   0: v = 32'(if0.tx);  1: v = 32'(if0.pronto); 2: v = 32'(if0.fim);
                   3: v = 32'(if0.Sel); default: v = 32'(if0.B);
               endcase
            1: case (sig)
                   0: v = 32'(if1.tx);  1: v = 32'(if1.pronto); 2: v = 32'(if1.fim);
                   3: v = 32'(if1.Sel); default: v = 32'(if1.B);
               endcase
            default: case (sig)
                   0: v = 32'(if2.tx);  1: v = 32'(if2.pronto); 2: v = 32'(if2.fim);
                   3: v = 32'(if2.Sel); default: v = 32'(if2.B);
               endcase
        endcase
        return v;
    endfunction

    task automatic drive(input int i, input logic ini, input logic [7:0] d);
        case (i)
            0: begin if0.inicio = ini; if0.dado = d; end
            1: begin if1.inicio = ini; if1.dado = d; end
            default: begin if2.inicio = ini; if2.dado = d; end
        endcase
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level for bit slot j of a frame: start, 8 data LSB first, parity?, stop.
    function automatic logic exp_tx(input logic [7:0] d, input int p, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (p != 0 && j == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic check_idle_state(input int i, input logic [7:0] exp_b, input string ctx);
        check_eq($sformatf("%s i%0d tx", ctx, i), rd(i, 0), 32'd1);
        check_eq($sformatf("%s i%0d pronto", ctx, i), rd(i, 1), 32'd1);
        check_eq($sformatf("%s i%0d fim", ctx, i), rd(i, 2), 32'd0);
        check_eq($sformatf("%s i%0d Sel", ctx, i), rd(i, 3), 32'd0);
        check_eq($sformatf("%s i%0d B", ctx, i), rd(i, 4), 32'(exp_b));
    endtask

    task automatic idle_all(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'($urandom));
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_idle_state(i, last_b[i], "idle");
        end
    endtask

    // Called at a negedge with instance i ready. mode 0: inicio low during
    // the frame; 1: random inicio/dado; 2: inicio held high, dado random.
    // abort_at >= 0 pulls rst_n low after that many cycles of the frame.
    task automatic send_frame(input int i, input logic [7:0] d, input int mode, input int abort_at);
        int dv;
        int p;
        int len;
        int j;
        logic [31:0] sel_exp;
        dv  = div_of(i);
        p   = par_of(i);
        len = (10 + p) * dv;
        drive(i, 1'b1, d);
        for (int n = 0; n <= len; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                for (int k = 0; k < 3; k++) last_b[k] = 8'h00;
                check_idle_state(i, 8'h00, "rst");
                drive(i, 1'b0, 8'h00);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            j = n / dv;
            if (n < len) begin
                sel_exp = (j <= 8) ? 32'(j % 8) : 32'd0;
                check_eq($sformatf("i%0d tx n%0d", i, n), rd(i, 0), 32'(exp_tx(d, p, j)));
                check_eq($sformatf("i%0d pronto n%0d", i, n), rd(i, 1), 32'd0);
                check_eq($sformatf("i%0d fim n%0d", i, n), rd(i, 2), 32'd0);
                check_eq($sformatf("i%0d Sel n%0d", i, n), rd(i, 3), sel_exp);
                check_eq($sformatf("i%0d B n%0d", i, n), rd(i, 4), 32'(d));
                case (mode)
                    0: drive(i, 1'b0, d);
                    1: drive(i, 1'($urandom), 8'($urandom));
                    default: drive(i, 1'b1, 8'($urandom));
                endcase
            end else begin
                check_eq($sformatf("i%0d end tx", i), rd(i, 0), 32'd1);
                check_eq($sformatf("i%0d end pronto", i), rd(i, 1), 32'd1);
                check_eq($sformatf("i%0d end fim", i), rd(i, 2), 32'd1);
                check_eq($sformatf("i%0d end Sel", i), rd(i, 3), 32'd0);
                check_eq($sformatf("i%0d end B", i), rd(i, 4), 32'(d));
                drive(i, 1'b0, 8'($urandom));
            end
        end
        last_b[i] = d;
    endtask

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 8'h00);
            last_b[i] = 8'h00;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check_idle_state(i, 8'h00, "reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        idle_all(100);

        send_frame(0, 8'hA5, 0, -1);
        idle_all(3);
        send_frame(1, 8'h07, 0, -1);
        idle_all(2);
        send_frame(2, 8'hFF, 0, -1);
        idle_all(2);

        // inicio held high with dado churning, then an immediate second frame
        send_frame(0, 8'h3C, 2, -1);
        send_frame(0, 8'hC3, 2, -1);
        send_frame(1, 8'h81, 2, -1);
        send_frame(1, 8'h7E, 1, -1);
        idle_all(1);

        for (int k = 0; k < 30; k++) begin
            int i;
            i = int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) idle_all(int'($urandom_range(1, 4)));
            send_frame(i, 8'($urandom), int'($urandom_range(0, 2)), -1);
        end
        idle_all(2);

        send_frame(0, 8'h5A, 0, 13);
        idle_all(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
